// File: rtl/lfsr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_gen
//  Description : Parametrised LFSR pseudo-random generator with runtime seed
//                load, enable-gated stepping, Fibonacci/Galois topology chosen
//                at load time, period measurement and return-to-seed pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module lfsr_gen #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             mode_in,
  output logic [WIDTH-1:0] lfsr_out,
  output logic             bit_out,
  output logic             mode,
  output logic             wrap,
  output logic [WIDTH-1:0] period_len,
  output logic             seed_err
);

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  // Parameter sanity: a mask without the top bit lets the state collapse to
  // zero, and a zero seed would lock the generator.
  generate
    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
      $error("lfsr_gen: WIDTH must be in 3..32");
    end
    if (TAPS[WIDTH-1] == 1'b0) begin : g_bad_taps
      $error("lfsr_gen: TAPS must include bit WIDTH-1");
    end
    if (SEED == '0) begin : g_bad_seed
      $error("lfsr_gen: SEED must be nonzero");
    end
  endgenerate

  logic [WIDTH-1:0] active_seed;
  logic [WIDTH-1:0] step_cnt;
  logic             fib_fb;
  logic [WIDTH-1:0] fib_next;
  logic [WIDTH-1:0] gal_next;
  logic [WIDTH-1:0] step_next;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] load_seed;

  // Next-state candidates for both topologies, serial bit and counter step.
  always_comb begin
    fib_fb    = ^(lfsr_out & TAPS);
    fib_next  = {lfsr_out[WIDTH-2:0], fib_fb};
    gal_next  = (lfsr_out >> 1) ^ (lfsr_out[0] ? TAPS : '0);
    step_next = mode ? gal_next : fib_next;
    bit_out   = mode ? lfsr_out[0] : lfsr_out[WIDTH-1];
    // Counter sticks at all-ones rather than rolling over to zero.
    cnt_inc   = (step_cnt == ALL_ONES) ? step_cnt : step_cnt + ONE;
    // A zero seed is replaced by SEED so the all-zero lock-up is unreachable.
    load_seed = (seed_in == '0) ? SEED : seed_in;
  end

  // State, active seed, period tracking and pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_out    <= SEED;
      active_seed <= SEED;
      mode        <= 1'b0;
      step_cnt    <= '0;
      period_len  <= '0;
      wrap        <= 1'b0;
      seed_err    <= 1'b0;
    end else if (load) begin
      lfsr_out    <= load_seed;
      active_seed <= load_seed;
      mode        <= mode_in;
      step_cnt    <= '0;
      wrap        <= 1'b0;
      seed_err    <= (seed_in == '0);
    end else if (en) begin
      lfsr_out <= step_next;
      seed_err <= 1'b0;
      if (step_next == active_seed) begin
        wrap       <= 1'b1;
        period_len <= step_cnt + ONE;
        step_cnt   <= '0;
      end else begin
        wrap     <= 1'b0;
        step_cnt <= cnt_inc;
      end
    end else begin
      wrap     <= 1'b0;
      seed_err <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lfsr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_gen
//  Description : Self-checking bench for lfsr_gen (WIDTH=8, TAPS=B8, SEED=1)
//                against a behavioural model of the generator's rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lfsr_gen;

  localparam int         W    = 8;
  localparam logic [7:0] TP   = 8'hB8;
  localparam logic [7:0] SD   = 8'h01;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         load;
  logic [W-1:0] seed_in;
  logic         mode_in;
  logic [W-1:0] lfsr_out;
  logic         bit_out;
  logic         mode;
  logic         wrap;
  logic [W-1:0] period_len;
  logic         seed_err;

  int checks = 0;
  int errors = 0;

  // Behavioural model
  logic [7:0] m_state, m_seed, m_period;
  logic       m_mode, m_wrap, m_serr;
  int         m_cnt;

  lfsr_gen #(.WIDTH(W), .TAPS(TP), .SEED(SD)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
    .mode_in(mode_in), .lfsr_out(lfsr_out), .bit_out(bit_out), .mode(mode),
    .wrap(wrap), .period_len(period_len), .seed_err(seed_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Next state from the polynomial description: Fibonacci shifts left and
  // appends the parity of the tapped bits; Galois shifts right and folds the
  // mask in whenever a one falls out of the bottom.
  function automatic logic [7:0] ref_next(input logic [7:0] s, input logic gal);
    int ones;
    if (!gal) begin
      ones = $countones(s & TP);
      return ((s * 2) % 256) + (ones % 2);
    end
    if (s % 2 == 1) return (s / 2) ^ TP;
    return s / 2;
  endfunction

  task automatic model_reset();
    m_state = SD; m_seed = SD; m_mode = 1'b0; m_cnt = 0;
    m_period = 8'h00; m_wrap = 1'b0; m_serr = 1'b0;
  endtask

  task automatic model_edge(input logic e, input logic l, input logic [7:0] s, input logic md);
    logic [7:0] nx;
    if (l) begin
      m_state = (s == 0) ? SD : s;
      m_seed  = m_state;
      m_serr  = (s == 0);
      m_mode  = md;
      m_cnt   = 0;
      m_wrap  = 1'b0;
    end else if (e) begin
      nx = ref_next(m_state, m_mode);
      m_serr = 1'b0;
      if (nx == m_seed) begin
        m_wrap = 1'b1; m_period = 8'(m_cnt + 1); m_cnt = 0;
      end else begin
        m_wrap = 1'b0;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
      end
      m_state = nx;
    end else begin
      m_wrap = 1'b0; m_serr = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".lfsr"},   lfsr_out,   m_state);
    chk({tag, ".bit"},    bit_out,    m_mode ? m_state[0] : m_state[7]);
    chk({tag, ".mode"},   mode,       m_mode);
    chk({tag, ".wrap"},   wrap,       m_wrap);
    chk({tag, ".period"}, period_len, m_period);
    chk({tag, ".serr"},   seed_err,   m_serr);
  endtask

  task automatic cyc(input string tag, input logic e, input logic l,
                     input logic [7:0] s, input logic md);
    en = e; load = l; seed_in = s; mode_in = md;
    @(posedge clk); #1;
    model_edge(e, l, s, md);
    check_all(tag);
  endtask

  task automatic do_reset();
    en = 0; load = 0; seed_in = 0; mode_in = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  logic [7:0] exp1 [6] = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47};
  logic [7:0] exp2 [5] = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};

  initial begin
    int wraps, wrap_at;
    logic [7:0] first_step;

    // Reset state
    do_reset();
    check_all("reset");
    chk("reset.lfsr_const", lfsr_out, 8'h01);
    chk("reset.bit_const", bit_out, 1'b0);

    // Fibonacci known answers from seed 01
    for (int i = 0; i < 6; i++) begin
      cyc("fib", 1, 0, 8'h00, 0);
      chk("fib.known", lfsr_out, exp1[i]);
    end

    // Galois known answers from seed 01
    cyc("gload", 0, 1, 8'h01, 1);
    chk("gload.bit", bit_out, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc("gal", 1, 0, 8'h00, 1);
      chk("gal.known", lfsr_out, exp2[i]);
    end

    // Full period in each mode
    for (int md = 0; md < 2; md++) begin
      do_reset();
      if (md == 1) cyc("pload", 0, 1, 8'h01, 1'b1);
      wraps = 0; wrap_at = -1;
      for (int i = 1; i <= 255; i++) begin
        cyc("period", 1, 0, 8'h00, 1'b0);
        if (i == 1) first_step = lfsr_out;
        if (wrap) begin wraps++; wrap_at = i; end
      end
      chk("period.wraps", wraps, 1);
      chk("period.at", wrap_at, 255);
      chk("period.len", period_len, 8'd255);
      chk("period.state", lfsr_out, 8'h01);
      cyc("period.again", 1, 0, 8'h00, 1'b0);
      chk("period.repeat", lfsr_out, first_step);
    end

    // Zero-seed substitution, then seed A5 period
    cyc("zload", 0, 1, 8'h00, 0);
    chk("zload.lfsr", lfsr_out, 8'h01);
    chk("zload.serr", seed_err, 1'b1);
    cyc("zload.after", 0, 0, 8'h00, 0);
    chk("zload.serr_clr", seed_err, 1'b0);
    cyc("a5load", 0, 1, 8'hA5, 0);
    chk("a5load.serr", seed_err, 1'b0);
    wrap_at = -1;
    for (int i = 1; i <= 255; i++) begin
      cyc("a5", 1, 0, 8'h00, 0);
      if (wrap && wrap_at < 0) wrap_at = i;
    end
    chk("a5.wrap_at", wrap_at, 255);
    chk("a5.state", lfsr_out, 8'hA5);

    // Enable toggling and load-beats-enable
    cyc("tog1", 1, 0, 8'h00, 0);
    cyc("tog0", 0, 0, 8'h00, 1);
    cyc("tog1b", 1, 0, 8'h00, 1);
    cyc("tog0b", 0, 0, 8'h00, 0);
    cyc("ldwin", 1, 1, 8'h3C, 0);
    chk("ldwin.state", lfsr_out, 8'h3C);
    chk("ldwin.wrap", wrap, 1'b0);
    chk("ldwin.serr", seed_err, 1'b0);

    // Async reset mid-sequence; first run a Galois period so period_len != 0
    cyc("arload", 0, 1, 8'h01, 1);
    for (int i = 0; i < 255; i++) cyc("arper", 1, 0, 8'h00, 0);
    cyc("arfib", 0, 1, 8'h01, 0);
    for (int i = 0; i < 100; i++) cyc("arrun", 1, 0, 8'h00, 0);
    chk("ar.period_pre", period_len, 8'd255);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    model_reset();
    chk("ar.lfsr", lfsr_out, 8'h01);
    chk("ar.period", period_len, 8'h00);
    chk("ar.mode", mode, 1'b0);
    #1 rst = 1'b0;
    cyc("ar.restart", 1, 0, 8'h00, 0);
    chk("ar.restart_val", lfsr_out, 8'h02);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      logic r_l, r_e, r_m;
      logic [7:0] r_s;
      r_l = ($urandom_range(0, 15) == 0);
      r_e = ($urandom_range(0, 3) != 0);
      r_m = 1'($urandom);
      r_s = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      cyc("rand", r_e, r_l, r_s, r_m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2_000_000;
    errors++;
    $display("FAIL timeout: observed running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
